// File: rtl/data_type_pkg.sv
// Shared FPU types: op codes, bfloat16 operand type, sequencer state and queue payloads.
package data_type_pkg;

    localparam int unsigned OP_W      = 4;
    localparam int unsigned BF16_W    = 16;
    localparam int unsigned OVF_CNT_W = 8;

    typedef logic [BF16_W-1:0] bf16_t;
    typedef logic [OP_W-1:0]   fpu_op_t;

    localparam fpu_op_t OP_ADD = 4'd0;
    localparam fpu_op_t OP_SUB = 4'd1;
    localparam fpu_op_t OP_MUL = 4'd2;
    localparam fpu_op_t OP_DIV = 4'd3;
    localparam fpu_op_t OP_MIN = 4'd4;
    localparam fpu_op_t OP_MAX = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } seq_state_e;

    // Command payload without the tag (tag width is a per-instance parameter).
    typedef struct packed {
        fpu_op_t op;
        bf16_t   a;
        bf16_t   b;
    } cmd_body_t;

    // Response payload without the tag.
    typedef struct packed {
        bf16_t data;
        logic  ovf;
    } rsp_body_t;

    localparam int unsigned CMD_BODY_W = $bits(cmd_body_t);
    localparam int unsigned RSP_BODY_W = $bits(rsp_body_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue read port and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_c;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_c = push_i && !full_c;
    assign do_pop_c  = pop_i && !empty_o;

    // Pointer and occupancy update; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Storage and pointer registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fpu_req_seq.sv
// Request sequencer: queues FPU commands, drives a combinational FPU core one
// command per cycle, and queues tagged results for an in-order response port.
module fpu_req_seq
    import data_type_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [OP_W-1:0]      cmd_op_i,
    input  logic [BF16_W-1:0]    cmd_a_i,
    input  logic [BF16_W-1:0]    cmd_b_i,
    input  logic [TAG_W-1:0]     cmd_tag_i,
    output logic [OP_W-1:0]      fpu_op_o,
    output logic [BF16_W-1:0]    fpu_in1_o,
    output logic [BF16_W-1:0]    fpu_in2_o,
    input  logic [BF16_W-1:0]    fpu_out_i,
    input  logic                 fpu_overflow_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [BF16_W-1:0]    rsp_data_o,
    output logic                 rsp_ovf_o,
    output logic [TAG_W-1:0]     rsp_tag_o,
    output logic [OVF_CNT_W-1:0] ovf_cnt_o,
    input  logic                 ovf_clr_i
);

    localparam int unsigned CMD_W     = CMD_BODY_W + TAG_W;
    localparam int unsigned RSP_W     = RSP_BODY_W + TAG_W;
    localparam int unsigned CMD_CNT_W = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned RSP_CNT_W = $clog2(RSP_DEPTH) + 1;

    seq_state_e           state_q, state_d;

    logic [CMD_W-1:0]     cmd_wdata, cmd_rdata;
    logic [CMD_CNT_W-1:0] cmd_cnt, cmd_cnt_nxt;
    logic                 cmd_empty;
    logic                 cmd_push_c;
    logic                 issue_c;
    cmd_body_t            head;
    logic [TAG_W-1:0]     head_tag;

    logic [RSP_W-1:0]     rsp_wdata, rsp_rdata;
    logic [RSP_CNT_W-1:0] rsp_cnt, rsp_cnt_nxt;
    logic                 rsp_empty;
    logic                 rsp_pop_c;
    rsp_body_t            rsp_head;

    cmd_body_t            drive_q, drive_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Command side: ready whenever the queue has room.
    assign cmd_ready_o = (cmd_cnt != CMD_CNT_W'(CMD_DEPTH));
    assign cmd_push_c  = cmd_valid_i && cmd_ready_o;
    assign cmd_wdata   = {cmd_op_i, cmd_a_i, cmd_b_i, cmd_tag_i};
    assign head        = cmd_rdata[CMD_W-1:TAG_W];
    assign head_tag    = cmd_rdata[TAG_W-1:0];

    // ISSUE is only entered when a head exists and the response queue has a slot.
    assign issue_c     = (state_q == ST_ISSUE) && !cmd_empty;

    // Response side: FPU result captured with the head tag in the issue cycle.
    assign rsp_wdata   = {fpu_out_i, fpu_overflow_i, head_tag};
    assign rsp_valid_o = !rsp_empty;
    assign rsp_pop_c   = rsp_valid_o && rsp_ready_i;
    assign rsp_head    = rsp_rdata[RSP_W-1:TAG_W];
    assign rsp_data_o  = rsp_head.data;
    assign rsp_ovf_o   = rsp_head.ovf;
    assign rsp_tag_o   = rsp_rdata[TAG_W-1:0];

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_push_c),
        .wdata_i (cmd_wdata),
        .pop_i   (issue_c),
        .rdata_o (cmd_rdata),
        .empty_o (cmd_empty),
        .count_o (cmd_cnt)
    );

    sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (issue_c),
        .wdata_i (rsp_wdata),
        .pop_i   (rsp_pop_c),
        .rdata_o (rsp_rdata),
        .empty_o (rsp_empty),
        .count_o (rsp_cnt)
    );

    // Next state from next-cycle occupancies; a pop this cycle frees a response slot.
    always_comb begin
        cmd_cnt_nxt = cmd_cnt + CMD_CNT_W'(cmd_push_c) - CMD_CNT_W'(issue_c);
        rsp_cnt_nxt = rsp_cnt + RSP_CNT_W'(issue_c) - RSP_CNT_W'(rsp_pop_c);
        state_d     = ST_IDLE;
        if (cmd_cnt_nxt != '0) begin
            state_d = (rsp_cnt_nxt == RSP_CNT_W'(RSP_DEPTH)) ? ST_STALL : ST_ISSUE;
        end
    end

    // FPU operand drive: head while issuing, otherwise hold the last issued operands.
    always_comb begin
        drive_d = drive_q;
        if (issue_c) drive_d = head;
    end

    assign fpu_op_o  = drive_d.op;
    assign fpu_in1_o = drive_d.a;
    assign fpu_in2_o = drive_d.b;

    // Saturating overflow counter; clear wins over a same-cycle increment.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr_i) begin
            ovf_cnt_d = '0;
        end else if (issue_c && fpu_overflow_i && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;

    // State, operand-hold and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            drive_q   <= '0;
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            drive_q   <= drive_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_fpu_req_seq.sv
// Directed bench for fpu_req_seq with a lookup-table stand-in for the FPU core.
module tb_fpu_req_seq;
    import data_type_pkg::*;

    localparam int unsigned TAG_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [3:0]       cmd_op_i;
    logic [15:0]      cmd_a_i;
    logic [15:0]      cmd_b_i;
    logic [TAG_W-1:0] cmd_tag_i;
    logic [3:0]       fpu_op_o;
    logic [15:0]      fpu_in1_o;
    logic [15:0]      fpu_in2_o;
    logic [15:0]      fpu_out_i;
    logic             fpu_overflow_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [15:0]      rsp_data_o;
    logic             rsp_ovf_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [7:0]       ovf_cnt_o;
    logic             ovf_clr_i;

    int errors = 0;
    int checks = 0;

    fpu_req_seq #(
        .CMD_DEPTH (4),
        .RSP_DEPTH (4),
        .TAG_W     (TAG_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_op_i       (cmd_op_i),
        .cmd_a_i        (cmd_a_i),
        .cmd_b_i        (cmd_b_i),
        .cmd_tag_i      (cmd_tag_i),
        .fpu_op_o       (fpu_op_o),
        .fpu_in1_o      (fpu_in1_o),
        .fpu_in2_o      (fpu_in2_o),
        .fpu_out_i      (fpu_out_i),
        .fpu_overflow_i (fpu_overflow_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_ovf_o      (rsp_ovf_o),
        .rsp_tag_o      (rsp_tag_o),
        .ovf_cnt_o      (ovf_cnt_o),
        .ovf_clr_i      (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // FPU core stand-in: known bfloat16 results for the directed vectors, a
    // distinct non-overflowing pattern for everything else. Returns {ovf, data}.
    function automatic logic [16:0] fpu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        if (op == OP_ADD && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
        if (op == OP_MUL && a == 16'h4000 && b == 16'h4000) return {1'b0, 16'h4080};
        if (op == OP_MUL && a == 16'h7F7F && b == 16'h7F7F) return {1'b1, 16'h7F80};
        return {1'b0, a ^ b ^ {op, 12'h000}};
    endfunction

    assign {fpu_overflow_i, fpu_out_i} = fpu_model(fpu_op_o, fpu_in1_o, fpu_in2_o);

    task automatic drive_cmd(input logic v, input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [TAG_W-1:0] tag);
        cmd_valid_i = v;
        cmd_op_i    = op;
        cmd_a_i     = a;
        cmd_b_i     = b;
        cmd_tag_i   = tag;
    endtask

    task automatic test_reset;
        logic [66:0] obs;
        rst_ni      = 1'b0;
        rsp_ready_i = 1'b0;
        ovf_clr_i   = 1'b0;
        drive_cmd(1'b0, 4'd0, 16'h0, 16'h0, '0);
        #12;
        obs = {cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_ovf_o, rsp_tag_o,
               fpu_op_o, fpu_in1_o, fpu_in2_o, ovf_cnt_o};
        checks++;
        if (obs !== {1'b1, 66'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, {1'b1, 66'h0});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_single_add;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        drive_cmd(1'b1, OP_ADD, 16'h3F80, 16'h4000, 4'd3);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_n1_valid: got %b expected 0", rsp_valid_o);
        end
        checks++;
        if ({fpu_op_o, fpu_in1_o, fpu_in2_o} !== {OP_ADD, 16'h3F80, 16'h4000}) begin
            errors++;
            $display("FAIL single_issue_drive: got %h/%h/%h expected 0/3f80/4000",
                     fpu_op_o, fpu_in1_o, fpu_in2_o);
        end
        @(negedge clk_i);
        checks++;
        if ({rsp_valid_o, rsp_data_o, rsp_ovf_o, rsp_tag_o} !== {1'b1, 16'h4040, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL single_rsp: got v=%b d=%h o=%b t=%0d expected v=1 d=4040 o=0 t=3",
                     rsp_valid_o, rsp_data_o, rsp_ovf_o, rsp_tag_o);
        end
        checks++;
        if ({fpu_op_o, fpu_in1_o, fpu_in2_o} !== {OP_ADD, 16'h3F80, 16'h4000}) begin
            errors++;
            $display("FAIL idle_hold_drive: got %h/%h/%h expected 0/3f80/4000",
                     fpu_op_o, fpu_in1_o, fpu_in2_o);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_popped: got valid %b expected 0", rsp_valid_o);
        end
    endtask

    task automatic test_back_to_back;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic exp_v;
            exp_v = (k >= 2) && (k <= 5);
            checks++;
            if (rsp_valid_o !== exp_v) begin
                errors++;
                $display("FAIL b2b_valid_k%0d: got %b expected %b", k, rsp_valid_o, exp_v);
            end else if (exp_v) begin
                checks++;
                if ({rsp_data_o, rsp_ovf_o, rsp_tag_o} !== {16'h4080, 1'b0, 4'(k - 2)}) begin
                    errors++;
                    $display("FAIL b2b_rsp_k%0d: got d=%h o=%b t=%0d expected d=4080 o=0 t=%0d",
                             k, rsp_data_o, rsp_ovf_o, rsp_tag_o, k - 2);
                end
            end
            if (k < 4) drive_cmd(1'b1, OP_MUL, 16'h4000, 16'h4000, 4'(k));
            else       cmd_valid_i = 1'b0;
            @(negedge clk_i);
        end
    endtask

    task automatic test_stall;
        int          idx;
        logic [15:0] exp_d;
        logic [16:0] m;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cmd_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_accept_%0d: got ready %b expected 1", i, cmd_ready_o);
            end
            drive_cmd(1'b1, OP_SUB, 16'h1000 + 16'(i), 16'h0100, 4'(i));
            @(negedge clk_i);
        end
        // A ninth command is offered while full and must be refused.
        drive_cmd(1'b1, OP_SUB, 16'h2222, 16'h0100, 4'd9);
        m = fpu_model(OP_SUB, 16'h1000, 16'h0100);
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_cmd_full: got ready %b expected 0", cmd_ready_o);
        end
        checks++;
        if (dut.state_q !== ST_STALL) begin
            errors++;
            $display("FAIL stall_state: got %0d expected %0d", dut.state_q, ST_STALL);
        end
        checks++;
        if ({rsp_valid_o, rsp_data_o, rsp_tag_o} !== {1'b1, m[15:0], 4'd0}) begin
            errors++;
            $display("FAIL stall_head: got v=%b d=%h t=%0d expected v=1 d=%h t=0",
                     rsp_valid_o, rsp_data_o, rsp_tag_o, m[15:0]);
        end
        repeat (2) @(negedge clk_i);
        cmd_valid_i = 1'b0;
        checks++;
        if ({rsp_valid_o, rsp_data_o, rsp_tag_o} !== {1'b1, m[15:0], 4'd0}) begin
            errors++;
            $display("FAIL stall_hold: got v=%b d=%h t=%0d expected v=1 d=%h t=0",
                     rsp_valid_o, rsp_data_o, rsp_tag_o, m[15:0]);
        end
        rsp_ready_i = 1'b1;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid_o === 1'b1) begin
                if (idx < 8) begin
                    m     = fpu_model(OP_SUB, 16'h1000 + 16'(idx), 16'h0100);
                    exp_d = m[15:0];
                    checks++;
                    if ({rsp_data_o, rsp_tag_o} !== {exp_d, 4'(idx)}) begin
                        errors++;
                        $display("FAIL stall_drain_%0d: got d=%h t=%0d expected d=%h t=%0d",
                                 idx, rsp_data_o, rsp_tag_o, exp_d, idx);
                    end
                end
                idx++;
            end
            @(negedge clk_i);
        end
        checks++;
        if (idx != 8) begin
            errors++;
            $display("FAIL stall_drain_count: got %0d responses expected 8", idx);
        end
    endtask

    task automatic test_overflow;
        rsp_ready_i = 1'b1;
        drive_cmd(1'b1, OP_MUL, 16'h7F7F, 16'h7F7F, 4'd5);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({rsp_valid_o, rsp_data_o, rsp_ovf_o, rsp_tag_o, ovf_cnt_o} !==
            {1'b1, 16'h7F80, 1'b1, 4'd5, 8'd1}) begin
            errors++;
            $display("FAIL ovf_single: got v=%b d=%h o=%b t=%0d cnt=%0d expected v=1 d=7f80 o=1 t=5 cnt=1",
                     rsp_valid_o, rsp_data_o, rsp_ovf_o, rsp_tag_o, ovf_cnt_o);
        end
        for (int i = 0; i < 300; i++) begin
            drive_cmd(1'b1, OP_MUL, 16'h7F7F, 16'h7F7F, 4'(i));
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checks++;
        if (ovf_cnt_o !== 8'd255) begin
            errors++;
            $display("FAIL ovf_saturate: got %0d expected 255", ovf_cnt_o);
        end
        // Clear asserted exactly in the issue cycle of an overflowing op.
        drive_cmd(1'b1, OP_MUL, 16'h7F7F, 16'h7F7F, 4'd7);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        ovf_clr_i   = 1'b1;
        @(negedge clk_i);
        ovf_clr_i   = 1'b0;
        checks++;
        if ({ovf_cnt_o, rsp_ovf_o} !== {8'd0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_clr_priority: got cnt=%0d ovf=%b expected cnt=0 ovf=1",
                     ovf_cnt_o, rsp_ovf_o);
        end
        drive_cmd(1'b1, OP_MUL, 16'h7F7F, 16'h7F7F, 4'd8);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (ovf_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL ovf_after_clr: got %0d expected 1", ovf_cnt_o);
        end
    endtask

    task automatic test_reset_midop;
        logic [66:0] obs;
        rsp_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive_cmd(1'b1, OP_MUL, 16'h7F7F, 16'h7F7F, 4'(i));
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
        checks++;
        if ({rsp_valid_o, ovf_cnt_o} !== {1'b1, 8'd3}) begin
            errors++;
            $display("FAIL midop_before: got v=%b cnt=%0d expected v=1 cnt=3",
                     rsp_valid_o, ovf_cnt_o);
        end
        #1 rst_ni = 1'b0;
        #1;
        obs = {cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_ovf_o, rsp_tag_o,
               fpu_op_o, fpu_in1_o, fpu_in2_o, ovf_cnt_o};
        checks++;
        if (obs !== {1'b1, 66'h0}) begin
            errors++;
            $display("FAIL midop_reset_outputs: got %h expected %h", obs, {1'b1, 66'h0});
        end
        @(negedge clk_i);
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            checks++;
            if ({rsp_valid_o, fpu_op_o, fpu_in1_o} !== {1'b0, 4'd0, 16'h0}) begin
                errors++;
                $display("FAIL midop_stale_%0d: got v=%b op=%h in1=%h expected v=0 op=0 in1=0",
                         c, rsp_valid_o, fpu_op_o, fpu_in1_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
